// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder slice.
package uart_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_DEPTH    = 16;
    localparam int DEF_ARM_WAIT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } feeder_state_t;

    // Pointer width for a power-of-two FIFO; a 1-entry FIFO still gets one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer-side byte stream (valid/ready) into the UART transmit feeder.
interface uart_tx_feeder_if
    import uart_pkg::*;
#(
    parameter int N = DEF_N
);
    logic [N-1:0] IN_DATA;
    logic         IN_VALID;
    logic         IN_READY;

    modport master (output IN_DATA, output IN_VALID, input IN_READY);
    modport slave  (input IN_DATA, input IN_VALID, output IN_READY);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Pushes while full and
// pops while empty are ignored. Read data is the current head (no fall-through:
// a pushed word is visible at the head only after the push edge).
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int N      = DEF_N,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              push,
    input  logic [N-1:0]      push_data,
    input  logic              pop,
    output logic [N-1:0]      pop_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [N-1:0]      mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (ADDR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge CLOCK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Transmit-side buffer in front of the UART: queues producer bytes and
// launches one per UART frame with a single-cycle WR pulse, holding the
// launched byte on UART_DATA for the whole frame.
// Optional feature: define UART_TX_FEEDER_LEVEL_EN to add the LEVEL output
// (registered FIFO occupancy).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a queued byte and an idle UART; launches on both
// ARM   | WR just issued; waiting up to ARM_WAIT cycles for BUSY to rise
// SEND  | UART transmitting; UART_DATA held until BUSY falls
// GAP   | one dead cycle so WR can never land while BUSY is still high
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int N        = DEF_N,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ARM_WAIT = DEF_ARM_WAIT,
    localparam int ADDR_W   = addr_w(DEPTH),
    localparam int CNT_W    = (ARM_WAIT > 1) ? $clog2(ARM_WAIT) : 1
) (
    input  logic            CLOCK,
    input  logic            RESET_N,
    uart_tx_feeder_if.slave in_bus,
    output logic [N-1:0]    UART_DATA,
    output logic            UART_WR,
    input  logic            UART_BUSY,
    output logic            EMPTY,
    output logic            FULL,
`ifdef UART_TX_FEEDER_LEVEL_EN
    output logic [ADDR_W:0] LEVEL,
`endif
    output logic            ERR_TMO
);

    feeder_state_t     state;
    logic [CNT_W-1:0]  arm_cnt;
    logic [N-1:0]      head_data;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W:0]   fifo_count;
    logic              push;
    logic              launch;

    assign in_bus.IN_READY = !fifo_full;
    assign push            = in_bus.IN_VALID && !fifo_full;
    assign launch          = (state == IDLE) && !fifo_empty && !UART_BUSY;
    assign EMPTY           = fifo_empty;
    assign FULL            = fifo_full;

`ifdef UART_TX_FEEDER_LEVEL_EN
    assign LEVEL = fifo_count;
`else
    logic unused_level;
    assign unused_level = ^fifo_count;
`endif

    uart_sync_fifo #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .push      (push),
        .push_data (in_bus.IN_DATA),
        .pop       (launch),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Launch/arm/send sequencing; WR and ERR_TMO are one-cycle registered
    // pulses, and UART_DATA is loaded only on a launch. The arm timer counts
    // down from ARM_WAIT-1 and times out at zero.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            arm_cnt   <= '0;
            UART_DATA <= '0;
            UART_WR   <= 1'b0;
            ERR_TMO   <= 1'b0;
        end else begin
            UART_WR <= 1'b0;
            ERR_TMO <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        UART_DATA <= head_data;
                        UART_WR   <= 1'b1;
                        arm_cnt   <= CNT_W'(ARM_WAIT - 1);
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (UART_BUSY) begin
                        state <= SEND;
                    end else if (arm_cnt == '0) begin
                        ERR_TMO <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        arm_cnt <= arm_cnt - 1'b1;
                    end
                end
                SEND: begin
                    if (!UART_BUSY) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
